// File: rtl/cu_ctrl_pkg.sv
// Shared encodings for the CU control path: opcodes, data-bus source codes,
// write-enable bit positions and the sequencer FSM states.
package cu_ctrl_pkg;

    localparam logic [7:0] NOP = 8'h80;

    // Opcode prefixes, compared against the top bits of ir.
    localparam logic       OP_LDI  = 1'b0;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [2:0] OP_ALU  = 3'b110;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_JNZ  = 4'b1111;

    localparam logic [3:0] SRC_X0    = 4'd0;
    localparam logic [3:0] SRC_X1    = 4'd1;
    localparam logic [3:0] SRC_Y0    = 4'd2;
    localparam logic [3:0] SRC_Y1    = 4'd3;
    localparam logic [3:0] SRC_R     = 4'd4;
    localparam logic [3:0] SRC_M     = 4'd5;
    localparam logic [3:0] SRC_I     = 4'd6;
    localparam logic [3:0] SRC_DM    = 4'd7;
    localparam logic [3:0] SRC_PM    = 4'd8;
    localparam logic [3:0] SRC_IPINS = 4'd9;
    localparam logic [3:0] SRC_ZERO  = 4'd10;

    localparam int RE_X0   = 0;
    localparam int RE_X1   = 1;
    localparam int RE_Y0   = 2;
    localparam int RE_Y1   = 3;
    localparam int RE_R    = 4;
    localparam int RE_M    = 5;
    localparam int RE_I    = 6;
    localparam int RE_DM   = 7;
    localparam int RE_OREG = 8;

    // Register codes that carry side effects on the index register.
    localparam logic [2:0] CODE_I  = 3'd6;
    localparam logic [2:0] CODE_DM = 3'd7;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } seq_state_e;

    // Destination code 4 addresses o_reg; the r register is only written by the ALU.
    function automatic logic [8:0] dst_to_reg_en(input logic [2:0] dst);
        logic [8:0] en;
        en = '0;
        case (dst)
            3'd0:    en[RE_X0]   = 1'b1;
            3'd1:    en[RE_X1]   = 1'b1;
            3'd2:    en[RE_Y0]   = 1'b1;
            3'd3:    en[RE_Y1]   = 1'b1;
            3'd4:    en[RE_OREG] = 1'b1;
            3'd5:    en[RE_M]    = 1'b1;
            3'd6:    en[RE_I]    = 1'b1;
            default: en[RE_DM]   = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into the CU control bundle
// plus jump indications for the sequencer.
module instr_decode
    import cu_ctrl_pkg::*;
(
    input  logic [7:0] ir_i,
    output logic [3:0] source_sel_o,
    output logic [8:0] reg_en_o,
    output logic       i_sel_o,
    output logic       x_sel_o,
    output logic       y_sel_o,
    output logic       is_jmp_o,
    output logic       is_jnz_o
);

    logic [2:0] dst;
    logic [2:0] src;

    always_comb begin
        source_sel_o = SRC_ZERO;
        reg_en_o     = '0;
        i_sel_o      = 1'b0;
        x_sel_o      = 1'b0;
        y_sel_o      = 1'b0;
        is_jmp_o     = 1'b0;
        is_jnz_o     = 1'b0;
        dst          = 3'd0;
        src          = 3'd0;

        if (ir_i[7] == OP_LDI) begin
            dst          = ir_i[6:4];
            source_sel_o = SRC_PM;
            reg_en_o     = dst_to_reg_en(dst);
            if (dst == CODE_DM) begin
                reg_en_o[RE_I] = 1'b1;
                i_sel_o        = 1'b1;
            end
        end else if (ir_i[7:6] == OP_MOVE) begin
            dst = ir_i[5:3];
            src = ir_i[2:0];
            // A move onto itself (including 8'h80) does nothing at all.
            if (dst != src) begin
                source_sel_o = {1'b0, src};
                reg_en_o     = dst_to_reg_en(dst);
                if (dst == CODE_DM || src == CODE_DM) begin
                    reg_en_o[RE_I] = 1'b1;
                    i_sel_o        = (dst != CODE_I);
                end
            end
        end else if (ir_i[7:5] == OP_ALU) begin
            x_sel_o        = ir_i[4];
            y_sel_o        = ir_i[3];
            reg_en_o[RE_R] = 1'b1;
        end else if (ir_i[7:4] == OP_JMP) begin
            is_jmp_o = 1'b1;
        end else begin
            is_jnz_o = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_decoder_sequencer.sv
// Fetch/execute sequencer for the 4-bit CU: pc, instruction register and FSM.
// Optional macro SEQ_HOLD_EN adds a hold input that freezes execution.
module instruction_decoder_sequencer
    import cu_ctrl_pkg::*;
#(
    parameter int PC_WIDTH     = 8,
    parameter int RESET_VECTOR = 0
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef SEQ_HOLD_EN
    input  logic                hold,
`endif
    input  logic [7:0]          pm_data,
    input  logic                r_eq_0,
    output logic [PC_WIDTH-1:0] pm_address,
    output logic [7:0]          ir,
    output logic                sync_reset,
    output logic [3:0]          source_sel,
    output logic [8:0]          reg_en,
    output logic                i_sel,
    output logic                x_sel,
    output logic                y_sel,
    output logic [3:0]          ir_nibble
);

    localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_VECTOR);

    seq_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] ir_addr_q, ir_addr_d;
    logic [7:0]          ir_q, ir_d;

    logic                hold_w;
    logic [8:0]          dec_reg_en;
    logic                dec_is_jmp;
    logic                dec_is_jnz;
    logic                take_jump;
    logic [PC_WIDTH-1:0] jump_target;

`ifdef SEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    instr_decode u_decode (
        .ir_i         (ir_q),
        .source_sel_o (source_sel),
        .reg_en_o     (dec_reg_en),
        .i_sel_o      (i_sel),
        .x_sel_o      (x_sel),
        .y_sel_o      (y_sel),
        .is_jmp_o     (dec_is_jmp),
        .is_jnz_o     (dec_is_jnz)
    );

    // Target page comes from the jump's own address, so a jump in slot 15 stays in its page.
    assign jump_target = {ir_addr_q[PC_WIDTH-1:4], ir_q[3:0]};
    assign take_jump   = dec_is_jmp | (dec_is_jnz & ~r_eq_0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_RESET;
            pc_q      <= PC_RST;
            ir_addr_q <= PC_RST;
            ir_q      <= NOP;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_addr_q <= ir_addr_d;
            ir_q      <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_addr_d = ir_addr_q;
        ir_d      = ir_q;

        case (state_q)
            S_RESET: begin
                state_d = S_FILL;
            end
            S_FILL, S_FLUSH: begin
                if (!hold_w) begin
                    ir_d      = pm_data;
                    ir_addr_d = pc_q;
                    pc_d      = pc_q + PC_WIDTH'(1);
                    state_d   = S_RUN;
                end
            end
            default: begin
                if (!hold_w) begin
                    ir_addr_d = pc_q;
                    if (take_jump) begin
                        // The word already fetched behind the jump is discarded.
                        ir_d    = NOP;
                        pc_d    = jump_target;
                        state_d = S_FLUSH;
                    end else begin
                        ir_d = pm_data;
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    assign reg_en     = (state_q == S_RESET || hold_w) ? 9'd0 : dec_reg_en;
    assign sync_reset = (state_q == S_RESET);
    assign pm_address = pc_q;
    assign ir         = ir_q;
    assign ir_nibble  = ir_q[3:0];

endmodule

// File: tb/tb_instruction_decoder_sequencer.sv
// Directed bench for instruction_decoder_sequencer with a combinational program ROM.
module tb_instruction_decoder_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       hold = 1'b0;
    logic [7:0] pm_data;
    logic       r_eq_0 = 1'b0;
    logic [7:0] pm_address;
    logic [7:0] ir;
    logic       sync_reset;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic [3:0] ir_nibble;

    logic [7:0] pm [256];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    always #5 clk = ~clk;

    assign pm_data = pm[pm_address];

    instruction_decoder_sequencer #(
        .PC_WIDTH     (8),
        .RESET_VECTOR (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef SEQ_HOLD_EN
        .hold       (hold),
`endif
        .pm_data    (pm_data),
        .r_eq_0     (r_eq_0),
        .pm_address (pm_address),
        .ir         (ir),
        .sync_reset (sync_reset),
        .source_sel (source_sel),
        .reg_en     (reg_en),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .ir_nibble  (ir_nibble)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) pm[a] = 8'h80;
        pm[8'h00] = 8'h05;  // ld x0,5
        pm[8'h01] = 8'hAF;  // m <- dm
        pm[8'h02] = 8'hB7;  // i <- dm
        pm[8'h03] = 8'hD2;  // alu x_sel=1 y_sel=0 f=2
        pm[8'h04] = 8'h80;  // nop
        pm[8'h05] = 8'hE8;  // jmp 0x08
        pm[8'h06] = 8'hE0;  // jmp 0x00, must be flushed
        pm[8'h17] = 8'hF3;  // jnz 0x13
        pm[8'h18] = 8'h4A;  // ld o_reg,A
        pm[8'h19] = 8'h7C;  // ld dm,C
        pm[8'h1A] = 8'hBE;  // dm <- i
        pm[8'hFF] = 8'hE0;  // jmp 0xF0
        pm[8'hF0] = 8'h13;  // ld x1,3

        #3 reset_n = 1'b0;
        step(2);
        chk("rst_sync_reset", sync_reset, 1);
        chk("rst_pc", pm_address, 8'h00);
        chk("rst_ir", ir, 8'h80);
        chk("rst_reg_en", reg_en, 9'h000);

        reset_n = 1'b1;
        #1 chk("rel_sync_reset", sync_reset, 1);
        step(1);
        chk("fill_sync_reset", sync_reset, 0);
        chk("fill_pc", pm_address, 8'h00);
        chk("fill_reg_en", reg_en, 9'h000);

        step(1);
        chk("ldi_ir", ir, 8'h05);
        chk("ldi_pc", pm_address, 8'h01);
        chk("ldi_src", source_sel, 4'd8);
        chk("ldi_nib", ir_nibble, 4'h5);
        chk("ldi_reg_en", reg_en, 9'h001);

        step(1);
        chk("mv_m_dm_src", source_sel, 4'd7);
        chk("mv_m_dm_reg_en", reg_en, 9'h060);
        chk("mv_m_dm_i_sel", i_sel, 1);

        step(1);
        chk("mv_i_dm_reg_en", reg_en, 9'h040);
        chk("mv_i_dm_i_sel", i_sel, 0);

        step(1);
        chk("alu_x_sel", x_sel, 1);
        chk("alu_y_sel", y_sel, 0);
        chk("alu_reg_en", reg_en, 9'h010);
        chk("alu_nib", ir_nibble, 4'h2);
        chk("alu_src", source_sel, 4'd10);

        step(1);
        chk("nop_reg_en", reg_en, 9'h000);
        chk("nop_pc", pm_address, 8'h05);

        step(1);
        chk("jmp_ir", ir, 8'hE8);
        step(1);
        chk("jmp_flush_ir", ir, 8'h80);
        chk("jmp_target", pm_address, 8'h08);
        step(1);
        chk("b2b_pc", pm_address, 8'h09);
        chk("b2b_ir", ir, 8'h80);

        step(15);
        chk("jnz_ir", ir, 8'hF3);
        chk("jnz_pc", pm_address, 8'h18);
        step(1);
        chk("jnz_taken_ir", ir, 8'h80);
        chk("jnz_taken_pc", pm_address, 8'h13);
        r_eq_0 = 1'b1;
        step(1);
        chk("jnz_refill_pc", pm_address, 8'h14);
        step(4);
        chk("jnz2_ir", ir, 8'hF3);
        chk("jnz2_reg_en", reg_en, 9'h000);
        step(1);
        chk("jnz_nt_pc", pm_address, 8'h19);
        chk("ld_oreg_ir", ir, 8'h4A);
        chk("ld_oreg_reg_en", reg_en, 9'h100);
        chk("ld_oreg_nib", ir_nibble, 4'hA);

`ifdef SEQ_HOLD_EN
        hold = 1'b1;
        #1 chk("hold_reg_en_0", reg_en, 9'h000);
        for (int h = 0; h < 3; h++) begin
            step(1);
            chk("hold_ir", ir, 8'h4A);
            chk("hold_pc", pm_address, 8'h19);
            chk("hold_reg_en", reg_en, 9'h000);
        end
        hold = 1'b0;
        #1 chk("resume_reg_en", reg_en, 9'h100);
`endif

        step(1);
        chk("ld_dm_ir", ir, 8'h7C);
        chk("ld_dm_pc", pm_address, 8'h1A);
        chk("ld_dm_reg_en", reg_en, 9'h0C0);
        chk("ld_dm_i_sel", i_sel, 1);
        chk("ld_dm_src", source_sel, 4'd8);

        step(1);
        chk("mv_dm_i_reg_en", reg_en, 9'h0C0);
        chk("mv_dm_i_i_sel", i_sel, 1);
        chk("mv_dm_i_src", source_sel, 4'd6);

        step(229);
        chk("wrap_ir", ir, 8'hE0);
        chk("wrap_pc", pm_address, 8'h00);
        step(1);
        chk("page_jmp_pc", pm_address, 8'hF0);
        chk("page_jmp_ir", ir, 8'h80);
        step(1);
        chk("page_tgt_ir", ir, 8'h13);
        chk("page_tgt_reg_en", reg_en, 9'h002);

        reset_n = 1'b0;
        #1;
        chk("async_rst_reg_en", reg_en, 9'h000);
        chk("async_rst_pc", pm_address, 8'h00);
        chk("async_rst_ir", ir, 8'h80);
        chk("async_rst_sync", sync_reset, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
